// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: horizontal/vertical counters with
// registered sync, active and line/frame strobes aligned to the coordinates.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_end,
  output logic          frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
      CW <= 0 || CW > 30 ||
      (1 << CW) < H_TOTAL || (1 << CW) < V_TOTAL) begin : g_bad_params
    $error("vga_timing_gen: illegal parameter set");
  end

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_nxt, v_nxt;

  always_comb begin
    h_nxt = hcount;
    v_nxt = vcount;
    if (reset) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (ce) begin
      if (hcount == H_LAST) begin
        h_nxt = '0;
        v_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
      end else begin
        h_nxt = hcount + 1'b1;
      end
    end
  end

  // Decode from the next-state counters so every output lands with its coordinate;
  // with ce=0 the next state equals the current one, so all outputs hold.
  always_ff @(posedge clk) begin
    hcount    <= h_nxt;
    vcount    <= v_nxt;
    hsync     <= (h_nxt >= HS_START && h_nxt < HS_END) ? HS_POL : ~HS_POL;
    vsync     <= (v_nxt >= VS_START && v_nxt < VS_END) ? VS_POL : ~VS_POL;
    active    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
    line_end  <= (h_nxt == H_LAST);
    frame_end <= (h_nxt == H_LAST) && (v_nxt == V_LAST);
  end

endmodule
